// File: rtl/stream_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : stream_upsizer
// Brief    : Valid/ready width converter packing Ratio narrow beats into one
//            registered wide beat. Optional strb_o via STREAM_UPSIZER_STRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_upsizer #(
    parameter int DataWidth = 8,
    parameter int Ratio     = 4,
    parameter int CntWidth  = $clog2(Ratio + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DataWidth-1:0]       data_i,
    input  logic                       last_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DataWidth*Ratio-1:0] data_o,
    output logic                       last_o,
    output logic [CntWidth-1:0]        count_o
`ifdef STREAM_UPSIZER_STRB_EN
    ,
    output logic [Ratio-1:0]           strb_o
`endif
);

    localparam int                  IdxWidth = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(Ratio - 1);

    logic [IdxWidth-1:0]             idx_q;
    logic [Ratio-1:0][DataWidth-1:0] lanes_q;
    logic [Ratio-1:0][DataWidth-1:0] word_next;
    logic [DataWidth*Ratio-1:0]      data_q;
    logic                            valid_q;
    logic                            last_q;
    logic [CntWidth-1:0]             count_q;
    logic                            completing;
    logic                            out_free;
    logic                            accept;
    logic                            load;

    assign completing = (idx_q == LastIdx) || last_i;
    assign out_free   = !valid_q || ready_i;
    // Only a completing beat needs room in the output register.
    assign ready_o    = !flush_i && (out_free || !completing);
    assign accept     = valid_i && ready_o;
    assign load       = accept && completing;

    always_comb begin
        word_next = '0;
        for (int k = 0; k < Ratio; k++) begin
            if (k < int'(idx_q)) begin
                word_next[k] = lanes_q[k];
            end else if (k == int'(idx_q)) begin
                word_next[k] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else if (flush_i || load) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else if (accept) begin
            lanes_q[idx_q] <= data_i;
            idx_q          <= idx_q + IdxWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= word_next;
            last_q  <= last_i;
            count_q <= CntWidth'(idx_q) + CntWidth'(1);
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign count_o = count_q;

`ifdef STREAM_UPSIZER_STRB_EN
    logic [Ratio-1:0] strb_next;
    logic [Ratio-1:0] strb_q;

    always_comb begin
        strb_next = '0;
        for (int k = 0; k < Ratio; k++) begin
            strb_next[k] = (k <= int'(idx_q));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strb_q <= '0;
        end else if (flush_i) begin
            strb_q <= '0;
        end else if (load) begin
            strb_q <= strb_next;
        end
    end

    assign strb_o = strb_q;
`endif

`ifndef SYNTHESIS
    // A flushed beat is discarded, so the source may change it afterwards.
    a_input_hold : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_o && !flush_i) |=> ($stable(data_i) && $stable(last_i)));

    a_count_range : assert property (@(posedge clk_i) disable iff (rst_i)
        valid_o |-> (count_o >= CntWidth'(1) && count_o <= CntWidth'(Ratio)));
`endif

endmodule
`default_nettype wire
